// File: rtl/sad_wta_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sad_wta_selector                                                 |
// | Brief   : Winner-take-all disparity search over windowed SAD sums.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sad_wta_selector #(
   parameter  int NUM_BITS = 8,
   parameter  int WIN      = 8,
   parameter  int MAX_DISP = 16,
   localparam int SAD_W    = NUM_BITS + $clog2(WIN),
   localparam int DISP_W   = (MAX_DISP > 2) ? $clog2(MAX_DISP) : 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                sync_clr,
   input  logic                in_valid,
   input  logic [NUM_BITS-1:0] diff_in,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DISP_W-1:0]   out_disp,
   output logic [SAD_W-1:0]    out_sad
);

   localparam int PIX_W = $clog2(WIN);
   localparam logic [PIX_W-1:0]  c_LAST_PIX  = PIX_W'(WIN - 1);
   localparam logic [DISP_W-1:0] c_LAST_DISP = DISP_W'(MAX_DISP - 1);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t              r_state,     w_state_nxt;
   logic [PIX_W-1:0]    r_pix,       w_pix_nxt;
   logic [DISP_W-1:0]   r_disp,      w_disp_nxt;
   logic [SAD_W-1:0]    r_acc,       w_acc_nxt;
   logic [SAD_W-1:0]    r_best_sad,  w_best_sad_nxt;
   logic [DISP_W-1:0]   r_best_disp, w_best_disp_nxt;

   logic                w_accept;
   logic [SAD_W-1:0]    w_sum;

   assign w_accept = (r_state == ACCUM) && in_valid;
   assign w_sum    = r_acc + SAD_W'(diff_in);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ACCUM;
         r_pix       <= '0;
         r_disp      <= '0;
         r_acc       <= '0;
         r_best_sad  <= '0;
         r_best_disp <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pix       <= w_pix_nxt;
         r_disp      <= w_disp_nxt;
         r_acc       <= w_acc_nxt;
         r_best_sad  <= w_best_sad_nxt;
         r_best_disp <= w_best_disp_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pix_nxt       = r_pix;
      w_disp_nxt      = r_disp;
      w_acc_nxt       = r_acc;
      w_best_sad_nxt  = r_best_sad;
      w_best_disp_nxt = r_best_disp;

      if (sync_clr) begin
         w_state_nxt     = ACCUM;
         w_pix_nxt       = '0;
         w_disp_nxt      = '0;
         w_acc_nxt       = '0;
         w_best_sad_nxt  = '0;
         w_best_disp_nxt = '0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  if (r_pix == c_LAST_PIX) begin
                     w_pix_nxt = '0;
                     w_acc_nxt = '0;
                     // Strict less-than keeps the lower disparity on ties.
                     if ((r_disp == '0) || (w_sum < r_best_sad)) begin
                        w_best_sad_nxt  = w_sum;
                        w_best_disp_nxt = r_disp;
                     end
                     if (r_disp == c_LAST_DISP) begin
                        w_disp_nxt  = '0;
                        w_state_nxt = HOLD;
                     end else begin
                        w_disp_nxt = r_disp + DISP_W'(1);
                     end
                  end else begin
                     w_pix_nxt = r_pix + PIX_W'(1);
                     w_acc_nxt = w_sum;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  w_state_nxt     = ACCUM;
                  w_pix_nxt       = '0;
                  w_disp_nxt      = '0;
                  w_acc_nxt       = '0;
                  w_best_sad_nxt  = '0;
                  w_best_disp_nxt = '0;
               end
            end
            default: w_state_nxt = ACCUM;
         endcase
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == HOLD);
   assign out_disp  = r_best_disp;
   assign out_sad   = r_best_sad;

endmodule
`default_nettype wire
